main_memory_ctrl: RTL and testbench

- Main-memory responder behind the direct-mapped data cache.
- Serves 128-bit block refills on a read miss and 32-bit write-through word stores.
- Has a fixed, parameterised access latency. Signals completion with a one-cycle `ok` pulse, which the cache control unit uses to finish a miss or store.
- Holds 1024 x 32-bit words; the word address is the same 10-bit address the cache uses.

---
 rtl/mem_pkg.sv | 11 +
 rtl/word_ram.sv | 27 ++
 rtl/main_memory_ctrl.sv | 92 +++++++++
 tb/tb_main_memory_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, default timing and FSM state type for the main-memory side of the cache.
package mem_pkg;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_LATENCY = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_e;
endpackage

// File: rtl/word_ram.sv
// Word array with one synchronous write port and a combinational aligned-block read.
module word_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [WORD_W-1:0]  i_wdata,
    input  logic [ADDR_W-3:0]  i_block,
    output logic [BLOCK_W-1:0] o_block
);
    logic [WORD_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Word k of the block lands at bits [32k+31:32k].
    for (genvar k = 0; k < WORDS_PER_BLOCK; k++) begin : g_rd
        localparam logic [1:0] SEL = 2'(k);
        assign o_block[WORD_W*k +: WORD_W] = r_mem[{i_block, SEL}];
    end
endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency main-memory responder: 128-bit block refills and 32-bit write-through stores.
module main_memory_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  address,
    input  logic [WORD_W-1:0]  data_in,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic [BLOCK_W-1:0] data_out,
    output logic               ok,
    output logic               busy
);
    mem_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_data;
    logic               r_ok;
    logic [BLOCK_W-1:0] r_data_out;

    logic               w_commit;
    logic               w_we;
    logic [BLOCK_W-1:0] w_block;

    assign w_commit = (r_state == WAIT) && (r_cnt == '0);
    // Reset on the commit edge must abort the store.
    assign w_we     = w_commit && r_op_write && !reset;

    word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_data),
        .i_block (r_addr[ADDR_W-1:2]),
        .o_block (w_block)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_ok       <= 1'b0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ok <= 1'b0;
                    if (mem_write || mem_read) begin
                        r_op_write <= mem_write;
                        r_addr     <= address;
                        r_data     <= data_in;
                        r_cnt      <= CNT_W'(LATENCY - 1);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_ok    <= 1'b1;
                        r_state <= DONE;
                        if (!r_op_write) begin
                            r_data_out <= w_block;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_ok    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ok    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign ok       = r_ok;
    assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench: cycle-level transaction model for the LATENCY=4 build plus a LATENCY=1 build.
module tb_main_memory_ctrl;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   address = '0;
    logic [31:0]  data_in = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [127:0] data_out;
    logic         ok;
    logic         busy;

    logic [9:0]   a1 = '0;
    logic [31:0]  d1 = '0;
    logic         r1 = 1'b0;
    logic         w1 = 1'b0;
    logic [127:0] dout1;
    logic         ok1;
    logic         busy1;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_memory_ctrl #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_out  (data_out),
        .ok        (ok),
        .busy      (busy)
    );

    main_memory_ctrl #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .address   (a1),
        .data_in   (d1),
        .mem_read  (r1),
        .mem_write (w1),
        .data_out  (dout1),
        .ok        (ok1),
        .busy      (busy1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: count edges since acceptance; access at LAT, idle again at LAT+1.
    logic [31:0]  m_mem [1024];
    bit           m_act = 1'b0;
    int           m_cnt = 0;
    bit           m_wr;
    logic [9:0]   m_addr;
    logic [31:0]  m_data;
    logic         exp_ok;
    logic         exp_busy;
    logic [127:0] exp_dout;

    always @(posedge clk) begin
        if (reset) begin
            m_act    <= 1'b0;
            exp_ok   <= 1'b0;
            exp_busy <= 1'b0;
            exp_dout <= '0;
        end else if (!m_act) begin
            if (mem_write || mem_read) begin
                m_act    <= 1'b1;
                m_cnt    <= 0;
                m_wr     <= mem_write;
                m_addr   <= address;
                m_data   <= data_in;
                exp_busy <= 1'b1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == LAT) begin
                exp_ok <= 1'b1;
                if (m_wr) m_mem[m_addr] <= m_data;
                else for (int k = 0; k < 4; k++)
                    exp_dout[32*k +: 32] <= m_mem[{m_addr[9:2], k[1:0]}];
            end else if (m_cnt + 1 == LAT + 1) begin
                m_act    <= 1'b0;
                exp_ok   <= 1'b0;
                exp_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ok_vs_model", {127'd0, ok}, {127'd0, exp_ok});
            chk("busy_vs_model", {127'd0, busy}, {127'd0, exp_busy});
            chk("dout_vs_model", data_out, exp_dout);
        end
    end

    int last_ok_cyc = 0;

    task automatic txn(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d,
                       output int lat, output int nbusy);
        @(negedge clk);
        mem_read = rd; mem_write = wr; address = a; data_in = d;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (ok) begin
                lat = i; last_ok_cyc = cyc;
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
        if (lat == 0) begin
            n_checks++; n_err++;
            $display("FAIL txn_timeout: got no ok want ok within 40 cycles (addr %h)", a);
            mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    task automatic wait_ok(output int lat);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (ok) begin lat = i; last_ok_cyc = cyc; end
        end
        if (lat == 0) begin
            n_checks++; n_err++;
            $display("FAIL wait_ok_timeout: got no ok want ok within 40 cycles");
        end
    endtask

    task automatic txn1(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        output int lat, output int nbusy);
        @(negedge clk);
        r1 = rd; w1 = wr; a1 = a; d1 = d;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (busy1) nbusy++;
            if (ok1) begin lat = i; r1 = 1'b0; w1 = 1'b0; end
        end
        if (lat == 0) begin
            n_checks++; n_err++;
            $display("FAIL txn1_timeout: got no ok want ok within 20 cycles");
            r1 = 1'b0; w1 = 1'b0;
        end
    endtask

    initial begin
        int lat, nb, t_first;
        logic [127:0] prev;

        @(negedge clk); @(negedge clk);
        chk("reset_ok", {127'd0, ok}, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_dout", data_out, 128'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            txn(0, 1, 10'h040 + 10'(i), 32'h11 * (i + 1), lat, nb);
            txn(0, 1, 10'h104 + 10'(i), 32'h1040 + i, lat, nb);
            txn(0, 1, 10'h020 + 10'(i), 32'h2000 + i, lat, nb);
            txn(0, 1, 10'h3FC + 10'(i), 32'h3FC0 + i, lat, nb);
            txn(0, 1, 10'h010 + 10'(i), 32'h0F0F0F0F + i, lat, nb);
        end

        txn(1, 0, 10'h042, 32'h0, lat, nb);
        chk("rd042_latency", 128'(lat), 128'(LAT + 1));
        chk("rd042_busy_cycles", 128'(nb), 128'(LAT + 1));
        chk("rd042_block", data_out, 128'h00000044_00000033_00000022_00000011);

        txn(0, 1, 10'h105, 32'hDEADBEEF, lat, nb);
        t_first = last_ok_cyc;
        txn(1, 0, 10'h104, 32'h0, lat, nb);
        chk("raw_word1", {96'd0, data_out[63:32]}, 128'hDEADBEEF);
        chk("raw_ok_spacing", 128'(last_ok_cyc - t_first), 128'(LAT + 2));

        prev = data_out;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b1; address = 10'h020; data_in = 32'hCAFE0001;
        wait_ok(lat);
        mem_write = 1'b0;
        chk("both_write_first_dout_kept", data_out, prev);
        t_first = last_ok_cyc;
        wait_ok(lat);
        mem_read = 1'b0;
        chk("both_read_second", {96'd0, data_out[31:0]}, 128'hCAFE0001);
        chk("both_spacing", 128'(last_ok_cyc - t_first), 128'(LAT + 2));

        @(negedge clk);
        mem_write = 1'b1; address = 10'h3FF; data_in = 32'h12345678;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            address = 10'h040 + 10'(i % 4); data_in = $urandom;
            if (ok) begin lat = i; mem_write = 1'b0; end
        end
        chk("scribble_latency", 128'(lat), 128'(LAT + 1));
        txn(1, 0, 10'h3FD, 32'h0, lat, nb);
        chk("wrap_block", data_out, {32'h12345678, 32'h3FC2, 32'h3FC1, 32'h3FC0});
        txn(1, 0, 10'h041, 32'h0, lat, nb);
        chk("scribble_untouched", data_out, 128'h00000044_00000033_00000022_00000011);

        // Requests dropped mid-WAIT: the transaction must still finish.
        @(negedge clk);
        mem_read = 1'b1; address = 10'h106;
        @(negedge clk);
        mem_read = 1'b0;
        $display("note: protocol violation, mem_read dropped during WAIT");
        wait_ok(lat);
        chk("drop_still_completes", 128'(lat), 128'(LAT));
        chk("drop_block", data_out, {32'h1043, 32'h1042, 32'hDEADBEEF, 32'h1040});

        @(negedge clk);
        mem_write = 1'b1; address = 10'h010; data_in = 32'hBAD0BAD0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        chk("midreset_ok", {127'd0, ok}, 128'd0);
        chk("midreset_busy", {127'd0, busy}, 128'd0);
        chk("midreset_dout", data_out, 128'd0);
        reset = 1'b0;
        txn(1, 0, 10'h010, 32'h0, lat, nb);
        chk("midreset_no_commit", {96'd0, data_out[31:0]}, 128'h0F0F0F0F);

        txn1(0, 1, 10'h005, 32'hA5A5A5A5, lat, nb);
        chk("lat1_write_latency", 128'(lat), 128'd2);
        chk("lat1_write_busy", 128'(nb), 128'd2);
        txn1(1, 0, 10'h004, 32'h0, lat, nb);
        chk("lat1_read_latency", 128'(lat), 128'd2);
        chk("lat1_read_word1", {96'd0, dout1[63:32]}, 128'hA5A5A5A5);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
